// File: rtl/morph_seq_pkg.sv
// Shared definitions for the morphological processor program sequencer:
// instruction layout, FSM state encoding and processor op codes.
package morph_seq_pkg;

  localparam int INSTR_W      = 17;
  localparam int LAST_BIT     = 16;
  localparam int LOGIC_OP_LSB = 13;
  localparam int SEL_BIT      = 12;
  localparam int MORPH_OP_LSB = 9;
  localparam int EL_W         = 9;

  // Packed view of one program word, MSB first, matching the bit offsets above.
  typedef struct packed {
    logic            last;
    logic [2:0]      logic_op;
    logic            morph_in_select;
    logic [2:0]      morph_op;
    logic [EL_W-1:0] el;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Morph operation codes understood by the morphologic unit.
  localparam logic [2:0] MOP_PASS   = 3'd0;
  localparam logic [2:0] MOP_ERODE  = 3'd1;
  localparam logic [2:0] MOP_DILATE = 3'd2;

  // Logic combine codes understood by the logic unit.
  localparam logic [2:0] LOP_COPY = 3'd0;
  localparam logic [2:0] LOP_AND  = 3'd1;
  localparam logic [2:0] LOP_OR   = 3'd2;

  // Reinterpret a raw program word as an instruction.
  function automatic instr_t to_instr(input logic [INSTR_W-1:0] word);
    return instr_t'(word);
  endfunction

endpackage

// File: rtl/morph_program_sequencer_if.sv
// Host/config bus and processor control bundle of the program sequencer.
// Optional `step` signal is present only when MORPH_SEQ_STEP_EN is defined.
interface morph_program_sequencer_if #(
  parameter int AddrWidth = 3
) ();

  logic                                prog_we;
  logic [AddrWidth-1:0]                prog_addr;
  logic [morph_seq_pkg::INSTR_W-1:0]   prog_wdata;
  logic                                start;
  logic                                abort;
`ifdef MORPH_SEQ_STEP_EN
  logic                                step;
`endif
  logic                                busy;
  logic                                done;
  logic                                err;
  logic [AddrWidth-1:0]                step_idx;
  logic                                proc_rst;
  logic                                proc_ce;
  logic [8:0]                          el;
  logic [2:0]                          morph_op;
  logic                                morph_in_select;
  logic [2:0]                          logic_op;

  // Host side: writes the program and requests runs.
  modport master (
    output prog_we, prog_addr, prog_wdata, start, abort,
`ifdef MORPH_SEQ_STEP_EN
    output step,
`endif
    input  busy, done, err, step_idx, proc_rst, proc_ce,
    input  el, morph_op, morph_in_select, logic_op
  );

  // Sequencer side.
  modport slave (
    input  prog_we, prog_addr, prog_wdata, start, abort,
`ifdef MORPH_SEQ_STEP_EN
    input  step,
`endif
    output busy, done, err, step_idx, proc_rst, proc_ce,
    output el, morph_op, morph_in_select, logic_op
  );

endinterface

// File: rtl/morph_prog_mem.sv
// Program store: ProgDepth x INSTR_W register file, synchronous write,
// asynchronous read. Contents are deliberately not reset.
module morph_prog_mem
  import morph_seq_pkg::*;
#(
  parameter int ProgDepth = 8,
  parameter int AddrWidth = 3
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [INSTR_W-1:0]   wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [INSTR_W-1:0]   rdata_o
);

  logic [INSTR_W-1:0] mem_q [ProgDepth];

  // Store one instruction word on a qualified write strobe.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/morph_program_sequencer.sv
// Program sequencer for the morphological image processor: clears the
// processor, issues one clock-enable per instruction, then pulses done.
// Optional single-step gating of passes: MORPH_SEQ_STEP_EN.
module morph_program_sequencer
  import morph_seq_pkg::*;
#(
  parameter int ProgDepth      = 8,
  parameter int AddrWidth      = 3,
  parameter int OpCounterWidth = 2
) (
  input logic                clk,
  input logic                rst_n,
  morph_program_sequencer_if.slave bus
);

  localparam int                   PassLimit = 1 << OpCounterWidth;
  localparam logic [AddrWidth-1:0] LastIdx   = AddrWidth'(ProgDepth - 1);

  seq_state_e           state_q;
  instr_t               instr_q;
  logic [AddrWidth-1:0] step_idx_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic                 proc_rst_q;
  logic                 proc_ce_q;

  logic [AddrWidth-1:0] next_idx_d;
  logic [AddrWidth-1:0] rd_addr_d;
  logic                 mem_we_d;
  logic                 final_pass_d;
  logic                 over_limit_d;
  logic                 step_en_d;
  logic [INSTR_W-1:0]   rd_data_s;

  // Read address, write qualification and end-of-program decisions.
  always_comb begin
    next_idx_d   = step_idx_q + AddrWidth'(1);
    rd_addr_d    = (state_q == ST_IDLE) ? '0 : next_idx_d;
    mem_we_d     = bus.prog_we && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    final_pass_d = instr_q.last || (step_idx_q == LastIdx);
    // The next pass would be number step_idx+2; beyond PassLimit the
    // processor op counter would wrap back to the source image.
    over_limit_d = (32'(step_idx_q) + 32'd2) > 32'(PassLimit);
`ifdef MORPH_SEQ_STEP_EN
    step_en_d    = bus.step;
`else
    step_en_d    = 1'b1;
`endif
  end

  morph_prog_mem #(
    .ProgDepth (ProgDepth),
    .AddrWidth (AddrWidth)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we_d),
    .waddr_i (bus.prog_addr),
    .wdata_i (bus.prog_wdata),
    .raddr_i (rd_addr_d),
    .rdata_o (rd_data_s)
  );

  // Sequencer FSM with all control outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      step_idx_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      proc_rst_q <= 1'b0;
      proc_ce_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      proc_rst_q <= 1'b0;
      // Program writes are refused while a run is in flight.
      if (bus.prog_we && ((state_q == ST_CLEAR) || (state_q == ST_RUN))) begin
        err_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            state_q    <= ST_CLEAR;
            instr_q    <= to_instr(rd_data_s);
            step_idx_q <= '0;
            err_q      <= 1'b0;
            proc_rst_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (bus.abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q   <= ST_RUN;
            proc_ce_q <= step_en_d;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            proc_ce_q <= 1'b0;
          end else if (!proc_ce_q) begin
            // No pass issued this cycle: hold fields and index.
            proc_ce_q <= step_en_d;
          end else if (final_pass_d) begin
            state_q   <= ST_DONE;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            proc_ce_q <= 1'b0;
          end else if (over_limit_d) begin
            state_q   <= ST_IDLE;
            err_q     <= 1'b1;
            busy_q    <= 1'b0;
            proc_ce_q <= 1'b0;
          end else begin
            step_idx_q <= next_idx_d;
            instr_q    <= to_instr(rd_data_s);
            proc_ce_q  <= step_en_d;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          busy_q    <= 1'b0;
          proc_ce_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.err             = err_q;
  assign bus.step_idx        = step_idx_q;
  assign bus.proc_rst        = proc_rst_q;
  assign bus.proc_ce         = proc_ce_q;
  assign bus.el              = instr_q.el;
  assign bus.morph_op        = instr_q.morph_op;
  assign bus.morph_in_select = instr_q.morph_in_select;
  assign bus.logic_op        = instr_q.logic_op;

endmodule

// File: tb/tb_morph_program_sequencer.sv
// Self-checking bench for morph_program_sequencer: directed scenarios plus
// random programs checked against a pass-count model of the program.
module tb_morph_program_sequencer;
  import morph_seq_pkg::*;

  localparam int ProgDepth = 8;
  localparam int AddrW     = 3;
  localparam int PassLimit = 4;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   done_cnt;
  logic [16:0] mem_m [ProgDepth];

  morph_program_sequencer_if #(.AddrWidth(AddrW)) bus ();

  morph_program_sequencer #(
    .ProgDepth      (ProgDepth),
    .AddrWidth      (AddrW),
    .OpCounterWidth (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_slot(input int addr, input logic [16:0] data);
    bus.prog_we    = 1'b1;
    bus.prog_addr  = AddrW'(addr);
    bus.prog_wdata = data;
    @(negedge clk);
    bus.prog_we    = 1'b0;
    mem_m[addr]    = data;
  endtask

  // Load every slot with random words; slots before lastpos never carry last.
  task automatic load_random(input int lastpos);
    logic [16:0] w;
    for (int i = 0; i < ProgDepth; i++) begin
      w = 17'($urandom);
      if (i == lastpos) w[16] = 1'b1;
      else if (i < lastpos) w[16] = 1'b0;
      write_slot(i, w);
    end
  endtask

  // Run the stored program and check every cycle against the model.
  task automatic run_check(input int abort_pass, input bit poke, input bit hold_start,
                           input bit wr0, input logic [16:0] wr0_data);
    int  n;
    int  passes;
    bit  ovf;
    bit  found;
    n = ProgDepth;
    found = 1'b0;
    for (int i = 0; i < ProgDepth; i++) begin
      if (!found && mem_m[i][16]) begin
        n = i + 1;
        found = 1'b1;
      end
    end
    ovf    = (n > PassLimit);
    passes = ovf ? PassLimit : n;

    bus.start = 1'b1;
    if (wr0) begin
      bus.prog_we    = 1'b1;
      bus.prog_addr  = '0;
      bus.prog_wdata = wr0_data;
    end
    @(negedge clk);
    bus.prog_we = 1'b0;
    if (!hold_start) bus.start = 1'b0;
    chk("clear_proc_rst", 32'(bus.proc_rst), 32'd1);
    chk("clear_busy", 32'(bus.busy), 32'd1);
    chk("clear_proc_ce", 32'(bus.proc_ce), 32'd0);
    chk("clear_err", 32'(bus.err), 32'd0);

    for (int p = 0; p < passes; p++) begin
      @(negedge clk);
      bus.prog_we = 1'b0;
      chk($sformatf("p%0d_proc_ce", p), 32'(bus.proc_ce), 32'd1);
      chk($sformatf("p%0d_busy", p), 32'(bus.busy), 32'd1);
      chk($sformatf("p%0d_done", p), 32'(bus.done), 32'd0);
      chk($sformatf("p%0d_proc_rst", p), 32'(bus.proc_rst), 32'd0);
      chk($sformatf("p%0d_step_idx", p), 32'(bus.step_idx), 32'(p));
      chk($sformatf("p%0d_fields", p),
          32'({bus.logic_op, bus.morph_in_select, bus.morph_op, bus.el}),
          32'(mem_m[p][15:0]));
      if (poke && p == 0) begin
        bus.prog_we    = 1'b1;
        bus.prog_addr  = '0;
        bus.prog_wdata = ~mem_m[0];
      end
      if (hold_start && p == passes - 1) bus.start = 1'b0;
      if (p == abort_pass) begin
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_proc_ce", 32'(bus.proc_ce), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        chk("abort_idle_done", 32'(bus.done), 32'd0);
        if (wr0) mem_m[0] = wr0_data;
        return;
      end
    end

    @(negedge clk);
    bus.prog_we = 1'b0;
    chk("end_done", 32'(bus.done), ovf ? 32'd0 : 32'd1);
    chk("end_busy", 32'(bus.busy), 32'd0);
    chk("end_proc_ce", 32'(bus.proc_ce), 32'd0);
    chk("end_err", 32'(bus.err), (ovf || poke) ? 32'd1 : 32'd0);
    @(negedge clk);
    chk("after_done", 32'(bus.done), 32'd0);
    chk("after_busy", 32'(bus.busy), 32'd0);
    if (wr0) mem_m[0] = wr0_data;
  endtask

  initial begin
    int d0;
    n_tests  = 0;
    n_fail   = 0;
    done_cnt = 0;
    rst_n          = 1'b0;
    bus.prog_we    = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_wdata = '0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
`ifdef MORPH_SEQ_STEP_EN
    bus.step       = 1'b1;
`endif
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_proc_rst", 32'(bus.proc_rst), 32'd0);
    chk("rst_proc_ce", 32'(bus.proc_ce), 32'd0);
    chk("rst_step_idx", 32'(bus.step_idx), 32'd0);
    chk("rst_fields", 32'({bus.logic_op, bus.morph_in_select, bus.morph_op, bus.el}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-pass program.
    write_slot(0, {1'b1, LOP_AND, 1'b1, MOP_DILATE, 9'h1FF});
    run_check(-1, 1'b0, 1'b0, 1'b0, '0);

    // Three passes, last on slot 2.
    load_random(2);
    run_check(-1, 1'b0, 1'b0, 1'b0, '0);

    // No last bit anywhere: pass-count limit trips.
    load_random(ProgDepth);
    run_check(-1, 1'b0, 1'b0, 1'b0, '0);

    // Abort in the second RUN cycle of a three-pass program.
    load_random(2);
    run_check(1, 1'b0, 1'b0, 1'b0, '0);

    // Program write during a run is refused; next start clears err and
    // still sees the original slot 0.
    run_check(-1, 1'b1, 1'b0, 1'b0, '0);
    run_check(-1, 1'b0, 1'b0, 1'b0, '0);

    // Start together with abort in IDLE is ignored.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("sa_proc_rst", 32'(bus.proc_rst), 32'd0);
    chk("sa_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("sa_busy2", 32'(bus.busy), 32'd0);

    // Start held high while busy produces exactly one run.
    d0 = done_cnt;
    run_check(-1, 1'b0, 1'b1, 1'b0, '0);
    repeat (2) @(negedge clk);
    chk("busy_start_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("busy_start_idle", 32'(bus.busy), 32'd0);

    // Writing slot 0 on the start edge: the old word is executed.
    load_random(1);
    run_check(-1, 1'b0, 1'b0, 1'b1, 17'($urandom));
    run_check(-1, 1'b0, 1'b0, 1'b0, '0);

    // Reset in the middle of a run.
    load_random(3);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_proc_ce", 32'(bus.proc_ce), 32'd0);
    chk("mrst_step_idx", 32'(bus.step_idx), 32'd0);
    chk("mrst_fields", 32'({bus.logic_op, bus.morph_in_select, bus.morph_op, bus.el}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_check(-1, 1'b0, 1'b0, 1'b0, '0);

    // Random programs, including ones without any last bit.
    for (int t = 0; t < 12; t++) begin
      load_random(int'($urandom_range(0, ProgDepth)));
      run_check(-1, 1'b0, 1'b0, 1'b0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
